// File: rtl/btn_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner: channel states,
// button index constants and a constant-function ceil(log2).
package btn_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PRESSED,
    HELD,
    DISARM
  } chan_state_t;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_INC        = 1;
  localparam int BTN_EDIT_SHIFT = 2;
  localparam int BTN_MODE       = 3;
  localparam int BTN_CLEAR      = 4;

  function automatic int clog2(input int unsigned value);
    int result;
    longint unsigned span;
    result = 0;
    span = 1;
    while (span < {32'd0, value}) begin
      span = span << 1;
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-flop synchronizer, debounce/hold/repeat FSM and its counter.
// The *_fire outputs announce a pulse that the top registers into the next cycle.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press_fire,
  output logic hold_fire,
  output logic repeat_fire,
  output logic release_fire
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES)
                              ? ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES)
                              : ((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam int CNT_W = (clog2(MAX_CYCLES) > 0) ? clog2(MAX_CYCLES) : 1;

  // The cycle that leaves IDLE/PRESSED/HELD already counts as the first stable one,
  // so the debounce states finish one count early.
  localparam bit SINGLE_DB = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic meta;
  logic sync;
  chan_state_t state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync) state <= SINGLE_DB ? PRESSED : ARM;
        end
        ARM: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync) begin
            state <= SINGLE_DB ? IDLE : DISARM;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= SINGLE_DB ? IDLE : DISARM;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DISARM: begin
          if (sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    press_fire   = sync && (((state == IDLE) && SINGLE_DB) || ((state == ARM) && (cnt == DB_LAST)));
    hold_fire    = sync && (state == PRESSED) && (cnt == HOLD_LAST);
    repeat_fire  = REPEAT_EN && sync && (state == HELD) && (cnt == REP_LAST);
    release_fire = !sync && ((((state == PRESSED) || (state == HELD)) && SINGLE_DB)
                             || ((state == DISARM) && (cnt == DB_LAST)));
  end

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: one btn_channel per button, then registered pulse outputs
// and a priority encoder reporting the highest-index press/repeat event.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] hold_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               evt_valid,
  output logic [2:0]         evt_id
);

  if (NUM_BTN < 1 || NUM_BTN > 8 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1)
  begin : g_param_check
    $error("btn_conditioner: NUM_BTN must be 1..8 and all cycle counts must be at least 1");
  end

  logic [NUM_BTN-1:0] press_fire;
  logic [NUM_BTN-1:0] hold_fire;
  logic [NUM_BTN-1:0] repeat_fire;
  logic [NUM_BTN-1:0] release_fire;
  logic [NUM_BTN-1:0] evt_fire;
  logic [2:0]         id_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .raw         (btn_raw[i]),
      .press_fire  (press_fire[i]),
      .hold_fire   (hold_fire[i]),
      .repeat_fire (repeat_fire[i]),
      .release_fire(release_fire[i])
    );
  end

  // Ascending scan so the highest-index event wins.
  always_comb begin
    evt_fire = press_fire | repeat_fire;
    id_next  = 3'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (evt_fire[i]) id_next = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_level     <= '0;
      press_pulse   <= '0;
      hold_pulse    <= '0;
      repeat_pulse  <= '0;
      release_pulse <= '0;
      evt_valid     <= 1'b0;
      evt_id        <= 3'd0;
    end else begin
      btn_level     <= (btn_level | press_fire) & ~release_fire;
      press_pulse   <= press_fire;
      hold_pulse    <= hold_fire;
      repeat_pulse  <= repeat_fire;
      release_pulse <= release_fire;
      evt_valid     <= |evt_fire;
      evt_id        <= id_next;
    end
  end

endmodule
